// File: rtl/ctrnn_pkg.sv
// Shared definitions for the CTRNN neuron: FSM state encoding, PLAN sigmoid
// breakpoints/offsets (scaled by the fractional width) and saturation helper.
package ctrnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYN   = 2'd1,
        INTEG = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide signed scratch type: holds any intermediate sum/product of the
    // datapath before it is clamped back to DATA_W.
    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // 1.0 in Q.frac_w; also the lowest PLAN breakpoint
    function automatic wide_t plan_one(input int frac_w);
        return wide_t'(1) <<< frac_w;
    endfunction

    // Breakpoint 5.0
    function automatic wide_t plan_bp_hi(input int frac_w);
        return wide_t'(5) <<< frac_w;
    endfunction

    // Breakpoint 2.375 = 19/8
    function automatic wide_t plan_bp_mid(input int frac_w);
        return (wide_t'(19) <<< frac_w) >>> 3;
    endfunction

    // Offset 0.84375 = 27/32
    function automatic wide_t plan_off_hi(input int frac_w);
        return (wide_t'(27) <<< frac_w) >>> 5;
    endfunction

    // Offset 0.625 = 5/8
    function automatic wide_t plan_off_mid(input int frac_w);
        return (wide_t'(5) <<< frac_w) >>> 3;
    endfunction

    // Offset 0.5
    function automatic wide_t plan_off_lo(input int frac_w);
        return (wide_t'(1) <<< frac_w) >>> 1;
    endfunction

    // Clamp to the signed range of a data_w-bit word
    function automatic wide_t sat(input wide_t x, input int data_w);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
        min_v = -(wide_t'(1) <<< (data_w - 1));
        if (x > max_v) begin
            return max_v;
        end else if (x < min_v) begin
            return min_v;
        end
        return x;
    endfunction

endpackage

// File: rtl/ctrnn_sigmoid_pwl.sv
// PLAN piecewise-linear sigmoid, purely combinational, shifts and adds only.
// Output is in [0, 1.0] in the same Q format as the input.
module ctrnn_sigmoid_pwl
    import ctrnn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] ONE     = DATA_W'(plan_one(FRAC_W));
    localparam logic [DATA_W-1:0] BP_HI   = DATA_W'(plan_bp_hi(FRAC_W));
    localparam logic [DATA_W-1:0] BP_MID  = DATA_W'(plan_bp_mid(FRAC_W));
    localparam logic [DATA_W-1:0] OFF_HI  = DATA_W'(plan_off_hi(FRAC_W));
    localparam logic [DATA_W-1:0] OFF_MID = DATA_W'(plan_off_mid(FRAC_W));
    localparam logic [DATA_W-1:0] OFF_LO  = DATA_W'(plan_off_lo(FRAC_W));
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] f;

    // Magnitude (most-negative maps to the largest positive), segment select,
    // then mirror around 0.5 for negative inputs
    always_comb begin
        if (x == $signed(MOST_NEG)) begin
            a = MAX_POS;
        end else if (x[DATA_W-1]) begin
            a = $unsigned(-x);
        end else begin
            a = $unsigned(x);
        end

        if (a >= BP_HI) begin
            f = ONE;
        end else if (a >= BP_MID) begin
            f = (a >> 5) + OFF_HI;
        end else if (a >= ONE) begin
            f = (a >> 3) + OFF_MID;
        end else begin
            f = (a >> 2) + OFF_LO;
        end

        if (x[DATA_W-1]) begin
            y = $signed(ONE - f);
        end else begin
            y = $signed(f);
        end
    end

endmodule

// File: rtl/ctrnn_neuron_seq.sv
// Time-multiplexed fixed-point CTRNN neuron, one forward-Euler step per
// transaction, one synapse per cycle through a single shared multiplier.
// Build option: CTRNN_STATE_REG_EN keeps y in an internal register that is
// updated with every result (self-recurrent neuron); y_t is then ignored.
//
// state | meaning
// IDLE  | ready for an operand set; capture on in_valid
// SYN   | accumulate w_k * sigma(sat(y_k + theta_k)), one k per cycle
// INTEG | d = sat(acc + I - y); y_next = sat(y + dt_tau * d)
// DONE  | present y_next until out_ready
module ctrnn_neuron_seq
    import ctrnn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int N_IN   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        y_t,
    input  logic [DATA_W-1:0]        dt_tau,
    input  logic [DATA_W-1:0]        input_i,
    input  logic [N_IN*DATA_W-1:0]   y_vec,
    input  logic [N_IN*DATA_W-1:0]   w_vec,
    input  logic [N_IN*DATA_W-1:0]   theta_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        y_next
);

    localparam int ACC_W = DATA_W + $clog2(N_IN) + 1;
    localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW    = 2 * DATA_W;
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]              k;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DATA_W-1:0]   y_r;
    logic signed [DATA_W-1:0]   dt_r;
    logic signed [DATA_W-1:0]   i_r;
    logic [N_IN*DATA_W-1:0]     y_vec_r;
    logic [N_IN*DATA_W-1:0]     w_vec_r;
    logic [N_IN*DATA_W-1:0]     theta_vec_r;
    logic signed [DATA_W-1:0]   y_next_r;

    logic signed [DATA_W-1:0]   y_k;
    logic signed [DATA_W-1:0]   w_k;
    logic signed [DATA_W-1:0]   th_k;
    logic signed [DATA_W-1:0]   s_k;
    logic signed [DATA_W-1:0]   sig_k;
    logic signed [DATA_W-1:0]   d_sat;
    logic signed [DATA_W-1:0]   mul_a;
    logic signed [DATA_W-1:0]   mul_b;
    logic signed [PW-1:0]       mul_p;
    logic signed [PW-1:0]       mul_sh;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic signed [DATA_W-1:0]   y_new;
    logic                       accept;

`ifdef CTRNN_STATE_REG_EN
    logic unused_y_t;
    assign unused_y_t = ^y_t;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_nxt = SYN;
                end
            end
            SYN: begin
                if (k == K_LAST) begin
                    state_nxt = INTEG;
                end
            end
            INTEG: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign y_next = y_next_r;

    // Current synapse operands and saturated sigmoid argument
    always_comb begin
        y_k  = $signed(y_vec_r[int'(k)*DATA_W +: DATA_W]);
        w_k  = $signed(w_vec_r[int'(k)*DATA_W +: DATA_W]);
        th_k = $signed(theta_vec_r[int'(k)*DATA_W +: DATA_W]);
        s_k  = DATA_W'(sat(wide_t'(y_k) + wide_t'(th_k), DATA_W));
    end

    ctrnn_sigmoid_pwl #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sigmoid (
        .x (s_k),
        .y (sig_k)
    );

    // Integration error term, clamped so it fits the shared multiplier port
    always_comb begin
        d_sat = DATA_W'(sat(wide_t'(acc) + wide_t'(i_r) - wide_t'(y_r), DATA_W));
    end

    // Shared multiplier operand select: synapse product in SYN, dt_tau * d in INTEG
    always_comb begin
        if (state == INTEG) begin
            mul_a = dt_r;
            mul_b = d_sat;
        end else begin
            mul_a = w_k;
            mul_b = sig_k;
        end
    end

    // Arithmetic shift truncates toward minus infinity
    assign mul_p   = mul_a * mul_b;
    assign mul_sh  = mul_p >>> FRAC_W;
    // |w * sigma| <= 2^(DATA_W-1), so the shifted product always fits ACC_W
    assign acc_nxt = acc + ACC_W'(mul_sh);
    assign y_new   = DATA_W'(sat(wide_t'(y_r) + wide_t'(mul_sh), DATA_W));

    // Operand capture, synapse accumulation and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            acc         <= '0;
            y_r         <= '0;
            dt_r        <= '0;
            i_r         <= '0;
            y_vec_r     <= '0;
            w_vec_r     <= '0;
            theta_vec_r <= '0;
            y_next_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k           <= '0;
                        acc         <= '0;
                        dt_r        <= $signed(dt_tau);
                        i_r         <= $signed(input_i);
                        y_vec_r     <= y_vec;
                        w_vec_r     <= w_vec;
                        theta_vec_r <= theta_vec;
`ifndef CTRNN_STATE_REG_EN
                        y_r         <= $signed(y_t);
`endif
                    end
                end
                SYN: begin
                    acc <= acc_nxt;
                    if (k == K_LAST) begin
                        k <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                INTEG: begin
                    y_next_r <= y_new;
`ifdef CTRNN_STATE_REG_EN
                    y_r      <= y_new;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrnn_neuron_seq.sv
// Scoreboard bench for ctrnn_neuron_seq: directed operand sets push hand-computed
// results; a monitor pops and compares each time out_valid rises.
// Honours CTRNN_STATE_REG_EN (self-recurrent sequence instead of the default one).
module tb_ctrnn_neuron_seq;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int N_IN   = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [DATA_W-1:0]      y_t = '0;
    logic [DATA_W-1:0]      dt_tau = '0;
    logic [DATA_W-1:0]      input_i = '0;
    logic [N_IN*DATA_W-1:0] y_vec = '0;
    logic [N_IN*DATA_W-1:0] w_vec = '0;
    logic [N_IN*DATA_W-1:0] theta_vec = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [DATA_W-1:0]      y_next;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      acc_cyc = 0;
    logic [31:0] exp_q[$];
    logic        prev_ov = 1'b0;

    ctrnn_neuron_seq #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_t       (y_t),
        .dt_tau    (dt_tau),
        .input_i   (input_i),
        .y_vec     (y_vec),
        .w_vec     (w_vec),
        .theta_vec (theta_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_next    (y_next)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Monitor: every new result is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                chk("latency", 64'(cyc - acc_cyc + 1), 64'(N_IN + 2));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", y_next);
                end else begin
                    chk("y_next", 64'(y_next), 64'(exp_q.pop_front()));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [31:0] yt, input logic [31:0] dt, input logic [31:0] ii,
                        input logic [127:0] yv, input logic [127:0] wv, input logic [127:0] tv,
                        input bit push, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        @(negedge clk);
        y_t = yt; dt_tau = dt; input_i = ii;
        y_vec = yv; w_vec = wv; theta_vec = tv;
        in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (push) exp_q.push_back(exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        in_valid = 1'b0;
        y_t = 32'hA5A5A5A5; dt_tau = 32'h5A5A5A5A; input_i = 32'h3C3C3C3C;
        y_vec = {4{32'h5A5A5A5A}}; w_vec = {4{32'hA5A5A5A5}}; theta_vec = {4{32'h0F0F0F0F}};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic reset_in_syn();
        send(32'h0, 32'h10000, 32'h0, pk(32'h10000, 32'h0, 32'h0, 32'h0),
             pk(32'h10000, 32'h10000, 32'h10000, 32'h10000), '0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_y_next", 64'(y_next), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        #2;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y_next", 64'(y_next), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

`ifdef CTRNN_STATE_REG_EN
        // y starts at 0 and follows the results; y_t must not matter
        send(32'h12345678, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h00010000);
        send(32'h12345678, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h00018000);
        send(32'h12345678, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h0001C000);
        drain();
        reset_in_syn();
        send(32'h12345678, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h00010000);
        drain();
`else
        // all zero operands
        send(32'h0, 32'h8000, 32'h0, '0, '0, '0, 1'b1, 32'h00000000);
        // sigma(0) = 0.5 on four unit weights
        send(32'h0, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h00010000);
        // top segment saturates at 1.0 / 0.0
        send(32'h0, 32'h10000, 32'h0, pk(32'h00060000, 0, 0, 0), pk(32'h10000, 0, 0, 0), '0, 1'b1, 32'h00010000);
        send(32'h0, 32'h10000, 32'h0, pk(32'hFFFA0000, 0, 0, 0), pk(32'h10000, 0, 0, 0), '0, 1'b1, 32'h00000000);
        // output saturation
        send(32'h7FFF0000, 32'h20000, 32'h7FFFFFFF, '0, '0, '0, 1'b1, 32'h7FFFFFFF);
        // breakpoints 1.0, 2.375 and -1.0 via theta: 0.75 + 0.91796875 + 0.25
        send(32'h0, 32'h10000, 32'h0, pk(32'h10000, 32'h26000, 32'h0, 32'h0),
             pk(32'h10000, 32'h10000, 32'h10000, 32'h0), pk(32'h0, 32'h0, 32'hFFFF0000, 32'h0),
             1'b1, 32'h0001EB00);
        // products round toward minus infinity
        send(32'h0, 32'h10000, 32'h0, '0, pk(32'hFFFFFFFF, 0, 0, 0), '0, 1'b1, 32'hFFFFFFFF);
        // input saturation and the most-negative sigmoid argument
        send(32'h0, 32'h10000, 32'h0, pk(32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0),
             pk(32'h10000, 32'h10000, 32'h0, 32'h0), pk(32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0),
             1'b1, 32'h00010000);
        drain();

        // backpressure: result held, new operand sets refused
        out_ready = 1'b0;
        send(32'h0, 32'h8000, 32'h0, '0, {4{32'h10000}}, '0, 1'b1, 32'h00010000);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 64'(out_valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            y_t = 32'h00100000;
            w_vec = {4{32'h00050000}};
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_y_next", 64'(y_next), 64'h00010000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(out_valid), 64'd0);
        drain();

        // reset mid-accumulation, then a fresh transaction
        reset_in_syn();
        send(32'h0, 32'h10000, 32'h0, pk(32'h10000, 32'h26000, 32'h0, 32'h0),
             pk(32'h10000, 32'h10000, 32'h10000, 32'h0), pk(32'h0, 32'h0, 32'hFFFF0000, 32'h0),
             1'b1, 32'h0001EB00);
        drain();
`endif
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
